fft_wb_ctrl: RTL and testbench

//  Write-back sequencer for the 16-point radix-2 in-place FFT. Accepts butterfly results
//  (X,Y pair tagged with stage/butterfly index), maps them to in-place RAM addresses and

---
 rtl/fft_pkg.sv | 45 ++++
 rtl/fft_wb_fifo.sv | 71 +++++++
 rtl/fft_wb_ctrl.sv | 150 +++++++++++++++
 tb/tb_fft_wb_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, types and the in-place address map for the 16-point FFT
//   Provides: transform sizing constants, tag/address/word typedefs, write-back FSM states,
//   inplace_addr(stage, idx) -> {A, B} used by both the read-address LUT and the write-back path.
package fft_pkg;

    localparam int N          = 16;
    localparam int LOG2N      = 4;
    localparam int NBF        = 8;
    localparam int NSTAGE     = 4;
    localparam int DEF_DATA_W = 16;
    localparam int NRESULT    = NBF * NSTAGE;

    typedef logic [1:0]              stage_t;
    typedef logic [2:0]              bf_idx_t;
    typedef logic [LOG2N-1:0]        addr_t;
    typedef logic [2*DEF_DATA_W-1:0] cword_t;

    typedef struct packed {
        addr_t a;
        addr_t b;
    } addr_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } wb_state_t;

    // A is the bit-reversed butterfly index with a zero spliced in at bit (3-stage);
    // B is the same address with that bit set (the butterfly span for the stage).
    function automatic addr_pair_t inplace_addr(input stage_t s, input bf_idx_t b);
        logic [2:0] r;
        addr_pair_t p;
        r = {b[0], b[1], b[2]};
        case (s)
            2'd0:    p.a = {1'b0, r};
            2'd1:    p.a = {r[2], 1'b0, r[1:0]};
            2'd2:    p.a = {r[2:1], 1'b0, r[0]};
            default: p.a = {r, 1'b0};
        endcase
        p.b = p.a | (addr_t'(4'b1000) >> s);
        return p;
    endfunction

endpackage

// File: rtl/fft_wb_fifo.sv
// rtl/fft_wb_fifo.sv - two-entry synchronous FIFO holding pending write-back pairs
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : synchronous flush (dominates push/pop)
//   push_i/din_i : write an entry (caller guarantees not full)
//   pop_i        : drop the head entry (caller guarantees not empty)
//   dout_o       : head entry, count_o : occupancy 0..2
module fft_wb_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            mem_d[0] = '0;
            mem_d[1] = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = din_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fft_wb_ctrl.sv
// rtl/fft_wb_ctrl.sv - FFT butterfly write-back sequencer with in-place addressing
//   clk_i, rst_i               : clock, synchronous active-high reset
//   start_i                    : arm / abort-and-restart a transform
//   bf_valid_i/bf_ready_o      : butterfly result handshake; bf_stage_i, bf_idx_i tag, bf_x_i/bf_y_i data
//   mem_ready_i                : RAM accepts the current write
//   wr_en_o, wr_{a,b}_addr_o, wr_{a,b}_data_o : dual-port write request
//   stage_done_o, done_stage_o, fft_done_o    : commit progress pulses
//   seq_err_o                  : sticky tag-order error
module fft_wb_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                bf_valid_i,
    output logic                bf_ready_o,
    input  logic [1:0]          bf_stage_i,
    input  logic [2:0]          bf_idx_i,
    input  logic [2*DATA_W-1:0] bf_x_i,
    input  logic [2*DATA_W-1:0] bf_y_i,
    input  logic                mem_ready_i,
    output logic                wr_en_o,
    output logic [3:0]          wr_a_addr_o,
    output logic [2*DATA_W-1:0] wr_a_data_o,
    output logic [3:0]          wr_b_addr_o,
    output logic [2*DATA_W-1:0] wr_b_data_o,
    output logic                stage_done_o,
    output logic [1:0]          done_stage_o,
    output logic                fft_done_o,
    output logic                seq_err_o
);

    localparam int EW = 2*LOG2N + 4*DATA_W;
    localparam logic [4:0] LAST = 5'(NRESULT - 1);

    wb_state_t  state_q, state_d;
    logic       ready_q, ready_d;
    logic [4:0] exp_q, exp_d;
    logic [4:0] commit_q, commit_d;
    logic       seq_err_q, seq_err_d;
    logic       stage_done_q, stage_done_d;
    logic [1:0] done_stage_q, done_stage_d;
    logic       fft_done_q, fft_done_d;

    logic          accept, push, pop, wr_en;
    addr_pair_t    ap;
    logic [EW-1:0] fifo_din, fifo_head;
    logic [1:0]    fifo_cnt, fifo_cnt_nxt;

    always_comb begin
        ap       = inplace_addr(bf_stage_i, bf_idx_i);
        fifo_din = {ap.a, ap.b, bf_x_i, bf_y_i};
        wr_en    = (fifo_cnt != 2'd0);
        accept   = bf_valid_i & ready_q;
        push     = accept & ~start_i;
        pop      = wr_en & mem_ready_i;

        state_d      = state_q;
        exp_d        = exp_q;
        commit_d     = commit_q;
        seq_err_d    = seq_err_q;
        stage_done_d = 1'b0;
        done_stage_d = done_stage_q;
        fft_done_d   = 1'b0;

        if (start_i) begin
            // start from any state restarts the transform; buffered writes are discarded
            state_d   = ST_RUN;
            exp_d     = 5'd0;
            commit_d  = 5'd0;
            seq_err_d = 1'b0;
        end else begin
            if (accept) begin
                exp_d = exp_q + 5'd1;
                if ({bf_stage_i, bf_idx_i} != exp_q) begin
                    seq_err_d = 1'b1;
                end
            end
            if (pop) begin
                commit_d = commit_q + 5'd1;
                if (commit_q[2:0] == 3'd7) begin
                    stage_done_d = 1'b1;
                    done_stage_d = commit_q[4:3];
                    fft_done_d   = (commit_q[4:3] == 2'd3);
                end
            end
            case (state_q)
                ST_RUN:   if (accept && exp_q == LAST) state_d = ST_FLUSH;
                ST_FLUSH: if (pop && commit_q == LAST) state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end

        if (start_i) begin
            fifo_cnt_nxt = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_cnt_nxt = fifo_cnt + 2'd1;
                2'b01:   fifo_cnt_nxt = fifo_cnt - 2'd1;
                default: fifo_cnt_nxt = fifo_cnt;
            endcase
        end
        // ready is registered, so it is derived from next-cycle state and occupancy
        ready_d = (state_d == ST_RUN) && (fifo_cnt_nxt < 2'd2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            exp_q        <= 5'd0;
            commit_q     <= 5'd0;
            seq_err_q    <= 1'b0;
            stage_done_q <= 1'b0;
            done_stage_q <= 2'd0;
            fft_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            exp_q        <= exp_d;
            commit_q     <= commit_d;
            seq_err_q    <= seq_err_d;
            stage_done_q <= stage_done_d;
            done_stage_q <= done_stage_d;
            fft_done_q   <= fft_done_d;
        end
    end

    fft_wb_fifo #(.W(EW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (start_i),
        .push_i  (push),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    assign bf_ready_o   = ready_q;
    assign wr_en_o      = wr_en;
    assign {wr_a_addr_o, wr_b_addr_o, wr_a_data_o, wr_b_data_o} = fifo_head;
    assign stage_done_o = stage_done_q;
    assign done_stage_o = done_stage_q;
    assign fft_done_o   = fft_done_q;
    assign seq_err_o    = seq_err_q;

endmodule

// File: tb/tb_fft_wb_ctrl.sv
// tb/tb_fft_wb_ctrl.sv - scoreboard bench for fft_wb_ctrl
module tb_fft_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, bf_valid, bf_ready, mem_ready;
    logic [1:0]  bf_stage, done_stage;
    logic [2:0]  bf_idx;
    logic [31:0] bf_x, bf_y, wr_a_data, wr_b_data;
    logic        wr_en, stage_done, fft_done, seq_err;
    logic [3:0]  wr_a_addr, wr_b_addr;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_wb_ctrl #(.DATA_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .bf_valid_i   (bf_valid),
        .bf_ready_o   (bf_ready),
        .bf_stage_i   (bf_stage),
        .bf_idx_i     (bf_idx),
        .bf_x_i       (bf_x),
        .bf_y_i       (bf_y),
        .mem_ready_i  (mem_ready),
        .wr_en_o      (wr_en),
        .wr_a_addr_o  (wr_a_addr),
        .wr_a_data_o  (wr_a_data),
        .wr_b_addr_o  (wr_b_addr),
        .wr_b_data_o  (wr_b_data),
        .stage_done_o (stage_done),
        .done_stage_o (done_stage),
        .fft_done_o   (fft_done),
        .seq_err_o    (seq_err)
    );

    typedef struct {
        logic [7:0]  ad;
        logic [31:0] x;
        logic [31:0] y;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   pq[$];
    int   nvec = 0, nerr = 0, n_acc = 0, tagn = 0, fft_cnt = 0;
    bit   chk_lat = 0;

    task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", nm, got, want);
        end
    endtask

    // independent arithmetic form of the in-place map: splice a zero into bitrev(b) at bit 3-s
    function automatic logic [7:0] exp_addr(input int s, input int b);
        int r, p, a;
        r = ((b & 1) << 2) | (b & 2) | ((b >> 2) & 1);
        p = 3 - s;
        a = ((r >> p) << (p + 1)) + (r % (1 << p));
        return {4'(a), 4'(a + (1 << p))};
    endfunction

    task automatic set_inputs(input int s, input int b);
        bf_stage = 2'(s);
        bf_idx   = 3'(b);
        bf_x     = {4'hA, 4'(s), 4'(b), 4'h0, 16'(tagn)};
        bf_y     = {16'(tagn) ^ 16'h5A5A, 4'h0, 4'(b), 4'(s), 4'hB};
        bf_valid = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] ad);
        exp_t e;
        e.ad  = ad;
        e.x   = bf_x;
        e.y   = bf_y;
        e.due = chk_lat ? cyc + 1 : -1;
        sb.push_back(e);
        tagn++;
        n_acc++;
        if (n_acc % 8 == 0) pq.push_back(n_acc / 8 - 1);
    endtask

    task automatic send(input int s, input int b, input logic [7:0] ad);
        int t;
        t = 0;
        set_inputs(s, b);
        while (!bf_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bf_ready) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: bf_ready=%0b required 1", bf_ready);
        end else begin
            push_exp(ad);
        end
        @(negedge clk);
        bf_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || pq.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 80'(sb.size() + pq.size()), 80'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_sb();
        sb.delete();
        pq.delete();
        n_acc = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {bf_ready, wr_en, stage_done, fft_done, seq_err, done_stage, wr_a_addr, wr_b_addr},
            80'd0);
        chk({nm, "_data"}, {wr_a_data, wr_b_data}, 80'd0);
    endtask

    // monitor: pops expected writes and stage pulses as the DUT presents them
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            #2;
            if (wr_en && mem_ready) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_write: got addr %0h/%0h required no write",
                             wr_a_addr, wr_b_addr);
                end else begin
                    e = sb.pop_front();
                    chk("write", {wr_a_addr, wr_b_addr, wr_a_data, wr_b_data}, {e.ad, e.x, e.y});
                    if (e.due >= 0) chk("write_latency", 80'(cyc), 80'(e.due));
                end
            end
            if (stage_done) begin
                if (pq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_stage_done: got stage %0d required none", done_stage);
                end else begin
                    k = pq.pop_front();
                    chk("done_stage", {fft_done, done_stage}, {(k == 3), 2'(k)});
                end
            end else if (fft_done) begin
                nvec++;
                nerr++;
                $display("FAIL fft_done_alone: got fft_done=1 required stage_done with it");
            end
            if (fft_done) fft_cnt++;
        end
    end

    initial begin
        int ta[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int nb, acc3;
        bit acc_now;

        rst = 1'b1; start = 1'b0; bf_valid = 1'b0; mem_ready = 1'b1;
        bf_stage = '0; bf_idx = '0; bf_x = '0; bf_y = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_outputs");
        start = 1'b1;                       // reset must win over start
        @(negedge clk);
        chk("rst_beats_start", bf_ready, 1'b0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // stage 0 back-to-back, single-cycle write latency
        chk_lat = 1;
        for (int b = 0; b < 8; b++) send(0, b, {4'(ta[b]), 4'(ta[b] + 8)});
        chk_lat = 0;
        // remaining stages: full address sweep and end-of-transform
        for (int s = 1; s < 4; s++)
            for (int b = 0; b < 8; b++) send(s, b, exp_addr(s, b));
        chk("flush_ready_low", bf_ready, 1'b0);
        wait_drain();
        chk("run1_seq_err", seq_err, 1'b0);
        chk("run1_fft_done_cnt", 80'(fft_cnt), 80'd1);
        chk("idle_ready_low", bf_ready, 1'b0);
        set_inputs(0, 0);
        repeat (4) @(negedge clk);
        bf_valid = 1'b0;
        chk("idle_ignored", {bf_ready, wr_en, seq_err}, 3'b000);

        // second transform: back-pressure with RAM stalled
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mem_ready = 1'b0;
        nb = 0; acc3 = 0;
        set_inputs(0, nb);
        repeat (5) begin
            acc_now = bf_ready;
            if (acc_now) push_exp({4'(ta[nb]), 4'(ta[nb] + 8)});
            @(negedge clk);
            if (acc_now) begin
                acc3++;
                nb++;
                set_inputs(0, nb);
            end
        end
        bf_valid = 1'b0;
        chk("stall_accepts", 80'(acc3), 80'd2);
        chk("stall_ready", bf_ready, 1'b0);
        chk("stall_head", {wr_en, wr_a_addr, wr_b_addr}, {1'b1, 4'd0, 4'd8});
        mem_ready = 1'b1;
        for (int b = 2; b < 8; b++) send(0, b, {4'(ta[b]), 4'(ta[b] + 8)});

        // out-of-order tag in stage 1
        send(1, 0, exp_addr(1, 0));
        send(1, 2, 8'h26);
        chk("seq_err_set", seq_err, 1'b1);
        send(1, 2, 8'h26);
        for (int b = 3; b < 8; b++) send(1, b, exp_addr(1, b));
        wait_drain();
        chk("seq_err_sticky", seq_err, 1'b1);

        // abort mid-stage 2 with one entry buffered
        mem_ready = 1'b0;
        send(2, 0, exp_addr(2, 0));
        chk("abort_pre_wr_en", wr_en, 1'b1);
        start = 1'b1;
        clear_sb();
        @(negedge clk);
        start = 1'b0;
        chk("abort_wr_en", wr_en, 1'b0);
        chk("abort_seq_err", seq_err, 1'b0);
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_write", wr_en, 1'b0);

        // fresh run from tag (0,0), then reset while in FLUSH
        for (int i = 0; i < 31; i++) send(i / 8, i % 8, exp_addr(i / 8, i % 8));
        wait_drain();
        chk("run3_seq_err", seq_err, 1'b0);
        mem_ready = 1'b0;
        send(3, 7, exp_addr(3, 7));
        chk("flush_hold", {bf_ready, wr_en}, 2'b01);
        rst = 1'b1;
        clear_sb();
        @(negedge clk);
        chk_all_zero("rst_in_flush");
        rst = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("final_fft_done_cnt", 80'(fft_cnt), 80'd1);
        chk("final_pending", 80'(sb.size() + pq.size()), 80'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
